lcd_bus_rd_engine: RTL and testbench

- Avalon-MM slave that executes 8080-style read cycles on the LCD parallel bus and returns the captured data word to the Nios master.
- It is the read-side counterpart of the write-side strobe PIOs.
- It owns lcd_rd_n, lcd_cs_n and lcd_rs during its cycles, and stalls the master with waitrequest until the data is captured.
- Sits between the Avalon fabric and the LCD pads; the write path is arbitrated externally using lcd_busy.

---
 rtl/lcd_rd_pkg.sv | 21 ++
 rtl/lcd_rd_timer.sv | 43 ++++
 rtl/lcd_bus_rd_engine.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_bus_rd_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rd_pkg.sv
// Shared definitions for the LCD 8080-style read engine: FSM state encoding,
// Avalon register map and the layout of the timing register.
package lcd_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_REG    = 2'd1;
  localparam logic [1:0] ADDR_TIMING = 2'd2;
  localparam logic [1:0] ADDR_LAST   = 2'd3;

  localparam int LOW_LSB  = 0;
  localparam int HIGH_LSB = 8;

endpackage

// File: rtl/lcd_rd_timer.sv
// Loadable down-counter shared by the STROBE and HOLD phases. The count is
// loaded with the phase length and stops at 1; 'last' flags the final cycle.
module lcd_rd_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; otherwise count down while enabled, never below 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q > ONE)) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == ONE);

endmodule

// File: rtl/lcd_bus_rd_engine.sv
// Avalon-MM slave running 8080-style read cycles on the LCD parallel bus.
// Reads of address 0/1 stall the master until the word is captured.
// Optional build macro LCD_RD_INREG_EN: registers lcd_data_in at the pad and
// captures from that register one cycle later (a HOLD cycle is forced when
// the programmed hold time is zero).
module lcd_bus_rd_engine
  import lcd_rd_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 8,
  parameter int RD_LOW_DEF  = 4,
  parameter int RD_HIGH_DEF = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  input  logic [DATA_W-1:0] lcd_data_in,
  output logic              lcd_rd_n,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_busy
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  state_e state_q, state_d;
  logic [CNT_W-1:0]  rd_low_q, rd_low_d, rd_high_q, rd_high_d;
  logic [CNT_W-1:0]  l_q, l_d, h_q, h_d;
  logic              rs_q, rs_d, rd_n_q, rd_n_d, cs_n_q, cs_n_d, busy_q, busy_d;
  logic [DATA_W-1:0] last_word_q, last_word_d;
  logic              rd_req_s, wr_timing_s, start_s;
  logic [CNT_W-1:0]  l_eff_s, hold_len_s, tmr_val_s;
  logic              hold_en_s, tmr_load_s, tmr_en_s, tmr_last_s;
  logic [31:0]       timing_word_s, last_word_ext_s;

  assign rd_req_s    = chipselect & ~read_n & ~address[1];
  assign wr_timing_s = chipselect & ~write_n & (address == ADDR_TIMING);
  assign start_s     = (state_q == ST_IDLE) & rd_req_s;
  assign l_eff_s     = (rd_low_q == ZERO) ? ONE : rd_low_q;

`ifdef LCD_RD_INREG_EN
  logic [DATA_W-1:0] pad_q;
  logic              cap_q, cap_d;

  // Pad data one cycle behind the bus; always hold at least one cycle so the
  // registered sample can be taken.
  assign hold_len_s = (h_q == ZERO) ? ONE : h_q;
  assign hold_en_s  = 1'b1;
  assign cap_d      = (state_q == ST_STROBE) & tmr_last_s;

  // Pad register and first-HOLD-cycle capture flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_q <= {DATA_W{1'b0}};
      cap_q <= 1'b0;
    end else begin
      pad_q <= lcd_data_in;
      cap_q <= cap_d;
    end
  end
`else
  assign hold_len_s = h_q;
  assign hold_en_s  = (h_q != ZERO);
`endif

  lcd_rd_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load_s),
    .en       (tmr_en_s),
    .load_val (tmr_val_s),
    .last     (tmr_last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; once started, a cycle always runs to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start_s ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: begin
        if (tmr_last_s) begin
          state_d = hold_en_s ? ST_HOLD : ST_DONE;
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_HOLD:   state_d = tmr_last_s ? ST_DONE : ST_HOLD;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: timer control for the current state, LCD pins for the next one.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    tmr_val_s  = l_q;
    case (state_q)
      ST_SETUP: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = l_q;
      end
      ST_STROBE: begin
        if (tmr_last_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = hold_len_s;
        end else begin
          tmr_en_s   = 1'b1;
        end
      end
      ST_HOLD:  tmr_en_s = 1'b1;
      default:  tmr_en_s = 1'b0;
    endcase
    rd_n_d = (state_d != ST_STROBE);
    cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD));
    busy_d = (state_d != ST_IDLE);
  end

  // Timing register, per-transaction latches and data capture.
  always_comb begin
    rd_low_d  = rd_low_q;
    rd_high_d = rd_high_q;
    if (wr_timing_s) begin
      rd_low_d  = writedata[LOW_LSB +: CNT_W];
      rd_high_d = writedata[HIGH_LSB +: CNT_W];
    end else begin
      rd_low_d  = rd_low_q;
      rd_high_d = rd_high_q;
    end
    l_d  = start_s ? l_eff_s : l_q;
    h_d  = start_s ? rd_high_q : h_q;
    rs_d = start_s ? ~address[0] : rs_q;
`ifdef LCD_RD_INREG_EN
    if (cap_q) begin
      last_word_d = pad_q;
    end else begin
      last_word_d = last_word_q;
    end
`else
    if ((state_q == ST_STROBE) && tmr_last_s) begin
      last_word_d = lcd_data_in;
    end else begin
      last_word_d = last_word_q;
    end
`endif
  end

  // Datapath and registered LCD output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_low_q    <= CNT_W'(RD_LOW_DEF);
      rd_high_q   <= CNT_W'(RD_HIGH_DEF);
      l_q         <= ONE;
      h_q         <= ZERO;
      rs_q        <= 1'b1;
      rd_n_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      last_word_q <= {DATA_W{1'b0}};
    end else begin
      rd_low_q    <= rd_low_d;
      rd_high_q   <= rd_high_d;
      l_q         <= l_d;
      h_q         <= h_d;
      rs_q        <= rs_d;
      rd_n_q      <= rd_n_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      last_word_q <= last_word_d;
    end
  end

  assign lcd_rd_n = rd_n_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_rs   = rs_q;
  assign lcd_busy = busy_q;

  assign timing_word_s   = (32'(rd_low_q) << LOW_LSB) | (32'(rd_high_q) << HIGH_LSB);
  assign last_word_ext_s = 32'(last_word_q);
  assign waitrequest     = rd_req_s & (state_q != ST_DONE);

  // Avalon read mux; bus-cycle data is only presented in DONE.
  always_comb begin
    readdata = 32'h0000_0000;
    if (chipselect && !read_n) begin
      case (address)
        ADDR_DATA, ADDR_REG: readdata = (state_q == ST_DONE) ? last_word_ext_s : 32'h0000_0000;
        ADDR_TIMING:         readdata = timing_word_s;
        ADDR_LAST:           readdata = last_word_ext_s;
        default:             readdata = 32'h0000_0000;
      endcase
    end else begin
      readdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_lcd_bus_rd_engine.sv
// Directed testbench for lcd_bus_rd_engine.
module tb_lcd_bus_rd_engine;

`ifdef LCD_RD_INREG_EN
  localparam int INREG = 1;
`else
  localparam int INREG = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [15:0] lcd_data_in = 16'h0;
  logic        lcd_rd_n, lcd_cs_n, lcd_rs, lcd_busy;

  int errors = 0;
  int checks = 0;

  lcd_bus_rd_engine dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .lcd_data_in(lcd_data_in), .lcd_rd_n(lcd_rd_n),
    .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_busy(lcd_busy)
  );

  always #5 clk = ~clk;

  // Running tallies of bus phases, sampled mid-cycle.
  int   mon_low = 0, mon_hold = 0, mon_setup = 0;
  logic mon_rs = 1'b1;
  logic seen_low = 1'b0;
  always @(negedge clk) begin
    if (lcd_cs_n !== 1'b0) begin
      seen_low <= 1'b0;
    end else if (lcd_rd_n === 1'b0) begin
      mon_low  <= mon_low + 1;
      seen_low <= 1'b1;
      mon_rs   <= lcd_rs;
    end else if (seen_low) begin
      mon_hold <= mon_hold + 1;
    end else begin
      mon_setup <= mon_setup + 1;
    end
  end

  function automatic int exp_stall(input int l, input int h);
    return 2 + l + h + ((h == 0) ? INREG : 0);
  endfunction

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [15:0] d,
                         output int stall, output logic [31:0] rd,
                         output int low, output int hold, output int setup,
                         output logic rs, output logic cs_done);
    int l0, h0, s0;
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0; lcd_data_in = d;
    #1;
    l0 = mon_low; h0 = mon_hold; s0 = mon_setup;
    stall = 0;
    while (waitrequest === 1'b1 && stall < 100) begin
      stall++;
      @(negedge clk); #1;
    end
    rd = readdata; cs_done = lcd_cs_n; rs = mon_rs;
    low = mon_low - l0; hold = mon_hold - h0; setup = mon_setup - s0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic test_reset();
    int st, lo, ho, se; logic [31:0] rd; logic rs, cd;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (lcd_rd_n !== 1'b1) begin errors++; $display("FAIL rst_rd_n got %b want 1", lcd_rd_n); end
    checks++; if (lcd_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b want 1", lcd_cs_n); end
    checks++; if (lcd_rs !== 1'b1) begin errors++; $display("FAIL rst_rs got %b want 1", lcd_rs); end
    checks++; if (lcd_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", lcd_busy); end
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL rst_wait got %b want 0", waitrequest); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", readdata); end
    @(negedge clk); reset_n = 1'b1;
    do_read(2'd2, 16'h0, st, rd, lo, ho, se, rs, cd);
    checks++; if (rd !== 32'h0000_0204) begin errors++; $display("FAIL rst_timing got %h want 00000204", rd); end
    checks++; if (st !== 0) begin errors++; $display("FAIL rst_timing_stall got %0d want 0", st); end
    do_read(2'd3, 16'h0, st, rd, lo, ho, se, rs, cd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_last got %h want 0", rd); end
  endtask

  task automatic test_default_read();
    int st, lo, ho, se; logic [31:0] rd; logic rs, cd;
    do_read(2'd0, 16'hA55A, st, rd, lo, ho, se, rs, cd);
    checks++; if (st !== exp_stall(4, 2)) begin errors++; $display("FAIL def_stall got %0d want %0d", st, exp_stall(4, 2)); end
    checks++; if (lo !== 4) begin errors++; $display("FAIL def_low got %0d want 4", lo); end
    checks++; if (se !== 1) begin errors++; $display("FAIL def_setup got %0d want 1", se); end
    checks++; if (ho !== 2) begin errors++; $display("FAIL def_hold got %0d want 2", ho); end
    checks++; if (rs !== 1'b1) begin errors++; $display("FAIL def_rs got %b want 1", rs); end
    checks++; if (rd !== 32'h0000_A55A) begin errors++; $display("FAIL def_data got %h want 0000a55a", rd); end
    checks++; if (cd !== 1'b1) begin errors++; $display("FAIL def_done_cs got %b want 1", cd); end
    do_read(2'd3, 16'h1234, st, rd, lo, ho, se, rs, cd);
    checks++; if (rd !== 32'h0000_A55A) begin errors++; $display("FAIL last_data got %h want 0000a55a", rd); end
    checks++; if (st !== 0 || lo !== 0) begin errors++; $display("FAIL last_nostall got stall=%0d low=%0d want 0/0", st, lo); end
  endtask

  task automatic test_short_timing();
    int st, lo, ho, se; logic [31:0] rd; logic rs, cd;
    do_write(2'd2, 32'h0000_0001);
    do_read(2'd1, 16'h0042, st, rd, lo, ho, se, rs, cd);
    checks++; if (st !== exp_stall(1, 0)) begin errors++; $display("FAIL short_stall got %0d want %0d", st, exp_stall(1, 0)); end
    checks++; if (lo !== 1 || se !== 1) begin errors++; $display("FAIL short_phases got low=%0d setup=%0d want 1/1", lo, se); end
    checks++; if (ho !== INREG) begin errors++; $display("FAIL short_hold got %0d want %0d", ho, INREG); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL short_rs got %b want 0", rs); end
    checks++; if (rd !== 32'h0000_0042) begin errors++; $display("FAIL short_data got %h want 00000042", rd); end
  endtask

  task automatic test_zero_low();
    int st, lo, ho, se; logic [31:0] rd; logic rs, cd;
    do_write(2'd2, 32'h0000_0200);
    do_read(2'd2, 16'h0, st, rd, lo, ho, se, rs, cd);
    checks++; if (rd !== 32'h0000_0200) begin errors++; $display("FAIL zlow_timing got %h want 00000200", rd); end
    do_read(2'd0, 16'hBEEF, st, rd, lo, ho, se, rs, cd);
    checks++; if (lo !== 1) begin errors++; $display("FAIL zlow_low got %0d want 1", lo); end
    checks++; if (st !== exp_stall(1, 2)) begin errors++; $display("FAIL zlow_stall got %0d want %0d", st, exp_stall(1, 2)); end
    checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL zlow_data got %h want 0000beef", rd); end
  endtask

  task automatic test_write_during_strobe();
    int st, lo, ho, se, cyc, l0, h0; logic [31:0] rd; logic rs, cd;
    do_write(2'd2, 32'h0000_0204);
    @(negedge clk);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0; lcd_data_in = 16'h5AA5;
    #1; l0 = mon_low; h0 = mon_hold;
    @(negedge clk); @(negedge clk); @(negedge clk);
    address = 2'd2; read_n = 1'b1; write_n = 1'b0; writedata = 32'h0000_0303;
    @(negedge clk);
    address = 2'd0; read_n = 1'b0; write_n = 1'b1;
    #1; cyc = 4;
    while (waitrequest === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk); #1;
    end
    rd = readdata;
    checks++; if (cyc !== 8) begin errors++; $display("FAIL wds_len got %0d want 8", cyc); end
    checks++; if (mon_low - l0 !== 4 || mon_hold - h0 !== 2) begin
      errors++; $display("FAIL wds_phases got low=%0d hold=%0d want 4/2", mon_low - l0, mon_hold - h0); end
    checks++; if (rd !== 32'h0000_5AA5) begin errors++; $display("FAIL wds_data got %h want 00005aa5", rd); end
    @(negedge clk); chipselect = 1'b0; read_n = 1'b1;
    do_read(2'd2, 16'h0, st, rd, lo, ho, se, rs, cd);
    checks++; if (rd !== 32'h0000_0303) begin errors++; $display("FAIL wds_timing got %h want 00000303", rd); end
    do_read(2'd0, 16'h0F0F, st, rd, lo, ho, se, rs, cd);
    checks++; if (lo !== 3 || ho !== 3) begin errors++; $display("FAIL next_phases got low=%0d hold=%0d want 3/3", lo, ho); end
    checks++; if (st !== exp_stall(3, 3)) begin errors++; $display("FAIL next_stall got %0d want %0d", st, exp_stall(3, 3)); end
  endtask

  task automatic test_drop_read();
    int l0;
    @(negedge clk);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    #1; l0 = mon_low;
    @(negedge clk); @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    checks++; if (mon_low - l0 !== 3) begin errors++; $display("FAIL drop_low got %0d want 3", mon_low - l0); end
    checks++; if (lcd_busy !== 1'b0 || lcd_cs_n !== 1'b1) begin
      errors++; $display("FAIL drop_idle got busy=%b cs_n=%b want 0/1", lcd_busy, lcd_cs_n); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    checks++; if (lcd_rd_n !== 1'b0) begin errors++; $display("FAIL midrst_pre got rd_n=%b want 0", lcd_rd_n); end
    #1; reset_n = 1'b0; #1;
    checks++; if (lcd_rd_n !== 1'b1 || lcd_cs_n !== 1'b1 || lcd_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_pins got %b%b%b want 110", lcd_rd_n, lcd_cs_n, lcd_busy); end
    address = 2'd2; #1;
    checks++; if (readdata !== 32'h0000_0204) begin errors++; $display("FAIL midrst_timing got %h want 00000204", readdata); end
    address = 2'd3; #1;
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL midrst_last got %h want 0", readdata); end
    chipselect = 1'b0; read_n = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_default_read();
    test_short_timing();
    test_zero_low();
    test_write_during_strobe();
    test_drop_read();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
